uart_word_loader: RTL and testbench

//  Downstream consumer of the 16x-oversampled UART receiver: packs received bytes into
//  32-bit little-endian words and writes them into instruction/data memory via a

---
 rtl/uart_word_loader_pkg.sv | 13 +
 rtl/uart_word_loader_if.sv | 14 +
 rtl/uart_word_loader_rx_event.sv | 37 +++
 rtl/uart_word_loader.sv | 160 ++++++++++++++++
 tb/tb_uart_word_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_word_loader_pkg.sv
// uart_loader_pkg: shared state encoding, lane count and error-counter helpers for the UART word loader
package uart_loader_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_e;

    localparam int         LANES   = 4;
    localparam logic [7:0] ERR_MAX = 8'hFF;

    function automatic logic [7:0] err_inc(input logic [7:0] v);
        return (v == ERR_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_word_loader_if.sv
// uart_word_loader_if: valid/ready memory write port
//   mem_valid  write request (master -> slave)
//   mem_ready  write accepted (slave -> master)
//   mem_addr   word address
//   mem_wdata  32-bit word data
interface uart_word_loader_if #(parameter int ADDR_W = 10);
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master(output mem_valid, mem_addr, mem_wdata, input mem_ready);
    modport slave (input mem_valid, mem_addr, mem_wdata, output mem_ready);
endinterface

// File: rtl/uart_word_loader_rx_event.sv
// uart_rx_event: turns the receiver's byte-valid level into a one-cycle byte event
//   clk, rst_n         clock, synchronous active-low reset
//   rx_data_i          receiver byte
//   rx_rdsig_i         receiver byte-valid level
//   rx_dataerror_i     parity error
//   rx_frameerror_i    stop-bit error
//   ev_o               one-cycle byte event
//   data_o, err_o      byte and combined error flag, valid while ev_o is high
module uart_rx_event (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data_i,
    input  logic       rx_rdsig_i,
    input  logic       rx_dataerror_i,
    input  logic       rx_frameerror_i,
    output logic       ev_o,
    output logic [7:0] data_o,
    output logic       err_o
);
    logic rdsig_q, armed_q;

    // rdsig resets high so the first post-reset fall is ignored; only a fall
    // preceded by an observed rise counts as a byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdsig_q <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            rdsig_q <= rx_rdsig_i;
            armed_q <= ev_o ? 1'b0 : (armed_q | (~rdsig_q & rx_rdsig_i));
        end
    end

    assign ev_o   = armed_q & rdsig_q & ~rx_rdsig_i;
    assign data_o = rx_data_i;
    assign err_o  = rx_dataerror_i | rx_frameerror_i;
endmodule

// File: rtl/uart_word_loader.sv
// uart_word_loader: packs UART bytes into little-endian 32-bit words and writes them to memory
//   clk, rst_n        clock, synchronous active-low reset
//   rx_*_i            receiver byte, byte-valid level, parity/stop-bit errors
//   clear_i           restart: address to BASE_ADDR, counters 0, partial/pending data dropped
//   mem               valid/ready write port (master)
//   word_count_o      words written, saturating
//   err_count_o       bad/dropped bytes, saturating at 255
//   busy_o            word in progress or held byte
//   checksum_o        XOR of written words, only when UART_LOADER_CHECKSUM_EN is defined
module uart_word_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int BASE_ADDR   = 0,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_rdsig_i,
    input  logic              rx_dataerror_i,
    input  logic              rx_frameerror_i,
    input  logic              clear_i,
    uart_word_loader_if.master mem,
    output logic [ADDR_W:0]   word_count_o,
    output logic [7:0]        err_count_o,
    output logic              busy_o
`ifdef UART_LOADER_CHECKSUM_EN
    ,output logic [31:0]      checksum_o
`endif
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic              ev, ev_err;
    logic [7:0]        ev_data;
    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic              hold_v_q, hold_v_d;
    logic [7:0]        hold_q, hold_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [7:0]        ecnt_q, ecnt_d;
    logic [TW-1:0]     tmo_q, tmo_d, tmo_inc;
    logic              hs;

    uart_rx_event u_ev (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data_i      (rx_data_i),
        .rx_rdsig_i     (rx_rdsig_i),
        .rx_dataerror_i (rx_dataerror_i),
        .rx_frameerror_i(rx_frameerror_i),
        .ev_o           (ev),
        .data_o         (ev_data),
        .err_o          (ev_err)
    );

    assign hs      = (state_q == WRITE) & mem.mem_ready;
    assign tmo_inc = tmo_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            word_q   <= '0;
            hold_v_q <= 1'b0;
            hold_q   <= '0;
            addr_q   <= ADDR_W'(BASE_ADDR);
            wcnt_q   <= '0;
            ecnt_q   <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            hold_v_q <= hold_v_d;
            hold_q   <= hold_d;
            addr_q   <= addr_d;
            wcnt_q   <= wcnt_d;
            ecnt_q   <= ecnt_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        word_d   = word_q;
        hold_v_d = hold_v_q;
        hold_d   = hold_q;
        addr_d   = addr_q;
        wcnt_d   = wcnt_q;
        ecnt_d   = ecnt_q;
        tmo_d    = tmo_q;
        if (clear_i) begin
            state_d  = IDLE;
            idx_d    = '0;
            hold_v_d = 1'b0;
            addr_d   = ADDR_W'(BASE_ADDR);
            wcnt_d   = '0;
            ecnt_d   = '0;
            tmo_d    = '0;
        end else if (state_q == WRITE) begin
            // a byte landing in the handshake cycle still goes through the
            // holding register so it seeds the next word
            if (ev) begin
                if (ev_err || hold_v_q) ecnt_d = err_inc(ecnt_q);
                else begin
                    hold_v_d = 1'b1;
                    hold_d   = ev_data;
                end
            end
            if (hs) begin
                addr_d   = addr_q + 1'b1;
                wcnt_d   = (&wcnt_q) ? wcnt_q : wcnt_q + 1'b1;
                state_d  = hold_v_d ? COLLECT : IDLE;
                idx_d    = hold_v_d ? 2'd1 : 2'd0;
                word_d   = {24'h0, hold_d};
                hold_v_d = 1'b0;
                tmo_d    = '0;
            end
        end else if (ev) begin
            if (ev_err) begin
                state_d = IDLE;
                idx_d   = '0;
                ecnt_d  = err_inc(ecnt_q);
            end else begin
                word_d[{idx_q, 3'b000} +: 8] = ev_data;
                idx_d   = idx_q + 1'b1;
                tmo_d   = '0;
                state_d = (idx_q == 2'(LANES - 1)) ? WRITE : COLLECT;
            end
        end else if (state_q == COLLECT) begin
            tmo_d = tmo_inc;
            if (tmo_inc == TW'(TIMEOUT_CYC)) begin
                state_d = IDLE;
                idx_d   = '0;
            end
        end
    end

    assign mem.mem_valid = (state_q == WRITE);
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = word_q;
    assign word_count_o  = wcnt_q;
    assign err_count_o   = ecnt_q;
    assign busy_o        = (state_q != IDLE) | hold_v_q;

`ifdef UART_LOADER_CHECKSUM_EN
    logic [31:0] chk_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) chk_q <= '0;
        else if (hs) chk_q <= chk_q ^ word_q;
    end

    assign checksum_o = chk_q;
`endif
endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: randomized and directed checks of uart_word_loader against a byte-queue model
module tb_uart_word_loader;
    localparam int AW   = 10;
    localparam int BASE = 0;
    localparam int TMO  = 200;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [7:0]  rx_data = 0;
    logic        rx_rdsig = 1;
    logic        rx_dataerror = 0;
    logic        rx_frameerror = 0;
    logic        clear = 0;
    logic [AW:0] word_count;
    logic [7:0]  err_count;
    logic        busy;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    uart_word_loader_if #(.ADDR_W(AW)) mem ();

    uart_word_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .TIMEOUT_CYC(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data_i      (rx_data),
        .rx_rdsig_i     (rx_rdsig),
        .rx_dataerror_i (rx_dataerror),
        .rx_frameerror_i(rx_frameerror),
        .clear_i        (clear),
        .mem            (mem),
        .word_count_o   (word_count),
        .err_count_o    (err_count),
        .busy_o         (busy)
`ifdef UART_LOADER_CHECKSUM_EN
        ,.checksum_o    (checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit ev_now  = 0;
    bit cmp_en  = 0;
    bit rand_ready = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes of the word being assembled, one completed word
    // awaiting acceptance, and one byte parked while that word waits.
    bit [7:0]    part[$];
    bit          pend;
    bit [31:0]   pword;
    bit          hv;
    bit [7:0]    hb;
    int          idle;
    bit [AW-1:0] m_addr;
    int          m_wc, m_ec;
    bit [31:0]   m_chk;

    function automatic int sat_err(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    always @(posedge clk) begin
        if (!rst_n || clear) begin
            part.delete();
            pend = 0; hv = 0; idle = 0;
            m_addr = AW'(BASE); m_wc = 0; m_ec = 0; m_chk = 0;
        end else if (pend) begin
            if (ev_now) begin
                if (rx_dataerror || rx_frameerror || hv) m_ec = sat_err(m_ec);
                else begin hv = 1; hb = rx_data; end
            end
            if (mem.mem_ready) begin
                m_addr = m_addr + 1'b1;
                m_wc++;
                m_chk ^= pword;
                pend = 0;
                if (hv) begin part.push_back(hb); hv = 0; idle = 0; end
            end
        end else if (ev_now) begin
            if (rx_dataerror || rx_frameerror) begin
                part.delete();
                m_ec = sat_err(m_ec);
            end else begin
                part.push_back(rx_data);
                idle = 0;
                if (part.size() == 4) begin
                    pword = {part[3], part[2], part[1], part[0]};
                    pend = 1;
                    part.delete();
                end
            end
        end else if (part.size() != 0) begin
            idle++;
            if (idle == TMO) part.delete();
        end
    end

    logic [AW-1:0] la[$];
    logic [31:0]   ld[$];

    always @(posedge clk)
        if (rst_n && !clear && mem.mem_valid && mem.mem_ready) begin
            la.push_back(mem.mem_addr);
            ld.push_back(mem.mem_wdata);
        end

    always @(negedge clk)
        if (cmp_en) begin
            check("mem_valid", 32'(mem.mem_valid), 32'(pend));
            check("mem_addr", 32'(mem.mem_addr), 32'(m_addr));
            if (pend) check("mem_wdata", mem.mem_wdata, pword);
            check("word_count", 32'(word_count), 32'(m_wc));
            check("err_count", 32'(err_count), 32'(m_ec));
            check("busy", 32'(busy), 32'(pend || hv || part.size() != 0));
`ifdef UART_LOADER_CHECKSUM_EN
            check("checksum", checksum, m_chk);
`endif
        end

    always @(negedge clk)
        if (rand_ready) mem.mem_ready = ($urandom_range(0, 3) != 0);

    task automatic send(input logic [7:0] d, input bit perr, input bit ferr, input int gap);
        @(negedge clk) rx_rdsig = 1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rx_data = d; rx_dataerror = perr; rx_frameerror = ferr; rx_rdsig = 0; ev_now = 1;
        @(negedge clk) ev_now = 0; rx_dataerror = 0; rx_frameerror = 0; rx_data = $urandom;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk) clear = 1;
        @(negedge clk) clear = 0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8], 0, 0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        mem.mem_ready = 1;
        repeat (4) @(negedge clk);
        rst_n = 1;
        cmp_en = 1;
        // post-reset fall of rdsig must not produce a byte
        @(negedge clk) rx_rdsig = 0;
        repeat (5) @(negedge clk);
        check("t1_valid", 32'(mem.mem_valid), 0);
        check("t1_err", 32'(err_count), 0);
        check("t1_busy", 32'(busy), 0);

        // single word, memory always ready
        send_word(32'h12345678);
        repeat (3) @(negedge clk);
        check("t2_nwrites", la.size(), 1);
        check("t2_addr", 32'(la[0]), 0);
        check("t2_data", ld[0], 32'h12345678);
        check("t2_wcnt", 32'(word_count), 1);

        // stall: AA parked, BB overruns
        pulse_clear();
        n0 = ld.size();
        mem.mem_ready = 0;
        send_word(32'h04030201);
        send(8'hAA, 0, 0, 0);
        send(8'hBB, 0, 0, 0);
        repeat (4) @(negedge clk);
        check("t3_stable", mem.mem_wdata, 32'h04030201);
        check("t3_err", 32'(err_count), 1);
        mem.mem_ready = 1;
        for (int i = 1; i < 4; i++) send(8'hC0 + 8'(i), 0, 0, 1);
        repeat (3) @(negedge clk);
        check("t3_nwrites", ld.size() - n0, 2);
        check("t3_word2", ld[ld.size()-1], 32'hC3C2C1AA);
        check("t3_addr2", 32'(la[la.size()-1]), 1);

        // parity error on third byte drops the partial word
        pulse_clear();
        send(8'h11, 0, 0, 1);
        send(8'h22, 0, 0, 1);
        send(8'h33, 1, 0, 1);
        check("t4_err", 32'(err_count), 1);
        send_word(32'hDEADBEEF);
        repeat (3) @(negedge clk);
        check("t4_addr", 32'(la[la.size()-1]), 0);
        check("t4_data", ld[ld.size()-1], 32'hDEADBEEF);

        // timeout discards a partial word silently
        pulse_clear();
        n0 = ld.size();
        send(8'h55, 0, 0, 0);
        send(8'h66, 0, 0, 0);
        repeat (TMO + 5) @(negedge clk);
        check("t5_busy", 32'(busy), 0);
        check("t5_nowrite", ld.size() - n0, 0);
        check("t5_err", 32'(err_count), 0);
        send_word(32'hCAFEF00D);
        repeat (3) @(negedge clk);
        check("t5_data", ld[ld.size()-1], 32'hCAFEF00D);

        // clear while a write is pending
        pulse_clear();
        mem.mem_ready = 0;
        send_word(32'h0BADC0DE);
        repeat (3) @(negedge clk);
        check("t6_valid_before", 32'(mem.mem_valid), 1);
        pulse_clear();
        check("t6_valid_after", 32'(mem.mem_valid), 0);
        check("t6_addr", 32'(mem.mem_addr), BASE);
        check("t6_wcnt", 32'(word_count), 0);
        mem.mem_ready = 1;
        send_word(32'h00FF00FF);
        send_word(32'h12481248);
        repeat (3) @(negedge clk);
        check("t6_wcnt2", 32'(word_count), 2);
`ifdef UART_LOADER_CHECKSUM_EN
        check("t6_checksum", checksum, 32'h00FF00FF ^ 32'h12481248);
`endif

        // randomized traffic with a randomly stalling memory
        pulse_clear();
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 80) == 0) pulse_clear();
            send($urandom, $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 6));
        end
        repeat (20) @(negedge clk);
        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
